csr_ram_sched: RTL

- Phase scheduler and port-A arbiter for the three CSR storage RAMs (value, column, row-pointer).
- Sequences a job as IDLE → LOAD → COMPUTE → DONE.
- During LOAD, only the loader may write. During COMPUTE, only the multiply engine may read.
- Tracks BRAM read latency so returned data arrives tagged with a valid strobe. Replaces the ad-hoc done-driven muxing in front of the RAMs.

---
 rtl/csr_ram_sched.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/csr_ram_sched.sv
// csr_ram_sched: phase scheduler and port-A arbiter for the CSR value/column/row-pointer RAMs.
// Sequences IDLE -> LOAD -> COMPUTE -> DONE and tags BRAM read returns with a valid strobe.
`default_nettype none

module csr_ram_sched #(
  parameter int AW     = 14,
  parameter int RAW    = 10,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           ld_req_i,
  input  logic [1:0]     ld_sel_i,
  input  logic [AW-1:0]  ld_addr_i,
  input  logic [DW-1:0]  ld_wdata_i,
  output logic           ld_gnt_o,
  input  logic           ld_done_i,
  input  logic           mul_req_i,
  input  logic [1:0]     mul_sel_i,
  input  logic [AW-1:0]  mul_addr_i,
  output logic           mul_gnt_o,
  output logic [DW-1:0]  mul_rdata_o,
  output logic           mul_rvalid_o,
  input  logic           mul_done_i,
  output logic           ram_en_val_o,
  output logic           ram_en_col_o,
  output logic           ram_en_row_o,
  output logic           ram_we_o,
  output logic [AW-1:0]  ram_addr_vc_o,
  output logic [RAW-1:0] ram_addr_row_o,
  output logic [DW-1:0]  ram_wdata_o,
  input  logic [DW-1:0]  ram_dout_val_i,
  input  logic [DW-1:0]  ram_dout_col_i,
  input  logic [DW-1:0]  ram_dout_row_i,
  output logic [1:0]     phase_o,
  output logic           done_o,
  output logic [AW:0]    nnz_o,
  output logic           err_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LOAD    = 2'b01,
    ST_COMPUTE = 2'b10,
    ST_DONE    = 2'b11
  } phase_e;

  localparam logic [1:0]  SEL_VAL = 2'b00;
  localparam logic [1:0]  SEL_COL = 2'b01;
  localparam logic [1:0]  SEL_BAD = 2'b11;
  localparam logic [AW:0] NNZ_MAX = {1'b1, {AW{1'b0}}};

  phase_e              state_q, state_d;
  logic                latch_q, latch_d;
  logic [AW:0]         nnz_q, nnz_d;
  logic                err_q, err_d;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q;
  logic [DW-1:0]       rdata_q;
  logic [RD_LAT-1:0]   pipe_v_q, pipe_v_d;
  logic [RD_LAT-1:0][1:0] pipe_sel_q, pipe_sel_d;

  logic          ld_gnt, mul_gnt, any_gnt, illegal, in_flight;
  logic [1:0]    acc_sel, ret_sel;
  logic [DW-1:0] ret_data;

  assign ld_gnt  = (state_q == ST_LOAD) && ld_req_i && (ld_sel_i != SEL_BAD);
  assign mul_gnt = (state_q == ST_COMPUTE) && mul_req_i && (mul_sel_i != SEL_BAD);
  assign any_gnt = ld_gnt | mul_gnt;
  assign acc_sel = ld_gnt ? ld_sel_i : mul_sel_i;
  assign illegal = (ld_req_i && (ld_sel_i == SEL_BAD)) || (mul_req_i && (mul_sel_i == SEL_BAD));

  assign ld_gnt_o       = ld_gnt;
  assign mul_gnt_o      = mul_gnt;
  assign ram_en_val_o   = any_gnt && (acc_sel == SEL_VAL);
  assign ram_en_col_o   = any_gnt && (acc_sel == SEL_COL);
  assign ram_en_row_o   = any_gnt && (acc_sel == 2'b10);
  assign ram_we_o       = ld_gnt;
  // Address and write data pass through on a grant and otherwise hold the last access.
  assign ram_addr_vc_o  = ld_gnt ? ld_addr_i : (mul_gnt ? mul_addr_i : addr_q);
  assign ram_addr_row_o = ram_addr_vc_o[RAW-1:0];
  assign ram_wdata_o    = ld_gnt ? ld_wdata_i : wdata_q;

  assign ret_sel   = pipe_sel_q[RD_LAT-1];
  assign in_flight = |pipe_v_q;

  always_comb begin
    case (ret_sel)
      SEL_VAL: ret_data = ram_dout_val_i;
      SEL_COL: ret_data = ram_dout_col_i;
      default: ret_data = ram_dout_row_i;
    endcase
  end

  assign mul_rvalid_o = pipe_v_q[RD_LAT-1];
  assign mul_rdata_o  = mul_rvalid_o ? ret_data : rdata_q;
  assign phase_o      = state_q;
  assign done_o       = (state_q == ST_DONE);
  assign nnz_o        = nnz_q;
  assign err_o        = err_q;

  always_comb begin
    pipe_v_d      = pipe_v_q;
    pipe_sel_d    = pipe_sel_q;
    pipe_v_d[0]   = mul_gnt;
    pipe_sel_d[0] = mul_sel_i;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_sel_d[i] = pipe_sel_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    nnz_d   = nnz_q;
    err_d   = err_q | illegal;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
          nnz_d   = '0;
          err_d   = 1'b0;
          latch_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_gnt && (ld_sel_i == SEL_VAL) && (nnz_q != NNZ_MAX)) begin
          nnz_d = nnz_q + (AW+1)'(1);
        end
        if (ld_done_i) begin
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (mul_done_i) begin
          latch_d = 1'b1;
        end
        // Leave only once every granted read has come back through the pipe.
        if (latch_q && !mul_gnt && !in_flight) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        latch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      latch_q    <= 1'b0;
      nnz_q      <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      pipe_v_q   <= '0;
      pipe_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      latch_q    <= latch_d;
      nnz_q      <= nnz_d;
      err_q      <= err_d;
      addr_q     <= ram_addr_vc_o;
      wdata_q    <= ram_wdata_o;
      rdata_q    <= mul_rdata_o;
      pipe_v_q   <= pipe_v_d;
      pipe_sel_q <= pipe_sel_d;
    end
  end

endmodule

`default_nettype wire
